data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning storage size in 32-bit words (power of 2, >= 4).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-005 SHALL have port req_valid  input  1  requester presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port resp_rdata  output  32  load result, extended to 32 bits.
REQ-013 SHALL have port resp_err  output  1  request was rejected (misaligned, illegal funct3, out of range).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where req_valid && req_ready, latching we, funct3, addr, wdata; inputs are ignored at all other times.
REQ-016 SHALL, on acceptance, load a wait counter with WAIT_STATES and go to WAIT, or go directly to RESP when WAIT_STATES = 0.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-018 SHALL drive resp_valid = 1 for exactly the one cycle spent in RESP, then return to IDLE; first resp_valid occurs WAIT_STATES+1 cycles after the acceptance edge.
REQ-019 SHALL start the next request no earlier than the cycle after RESP, for a throughput of one transaction per WAIT_STATES+2 cycles under continuous req_valid.
REQ-020 SHALL hold resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.
REQ-021 SHALL index storage with word = addr[2 +: log2(DEPTH_WORDS)], using little-endian byte lanes addr[1:0].
REQ-022 SHALL flag resp_err when: halfword access with addr[0] = 1; word access with addr[1:0] != 0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}; addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL, for an erroring request, commit no write and return resp_rdata = 0.
REQ-024 SHALL commit a legal store on the edge entering RESP, writing only the addressed byte lanes (sb 1 lane, sh 2 lanes, sw 4 lanes) from the low bits of wdata.
REQ-025 SHALL, for a legal load, return the addressed byte/halfword/word, sign-extended for funct3 000/001 and zero-extended for 100/101.
REQ-026 SHALL, for a store, return resp_rdata = 0.
REQ-027 SHALL read storage contents as of the acceptance edge; a store and a following load to the same word return the stored value.

Reset
REQ-028 SHALL, when reset = 0 at a rising edge, enter IDLE, clear the counter, and drive req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0 from the next cycle.
REQ-029 SHALL not initialise storage contents on reset.
REQ-030 SHALL, if reset is asserted while in WAIT, abort the transaction with no write committed and no response issued.

Verification
REQ-031 SHALL cover: sw addr 0x10 data 0xDEADBEEF, then lw addr 0x10 (WAIT_STATES = 2) -> resp_valid 3 cycles after each acceptance, second resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-032 SHALL cover: after REQ-031, lb addr 0x13 -> 0xFFFFFFDE; lbu addr 0x13 -> 0x000000DE; lh addr 0x10 -> 0xFFFFBEEF; lhu addr 0x12 -> 0x0000DEAD.
REQ-033 SHALL cover: sb addr 0x11 data 0x12345677 over 0xDEADBEEF, then lw 0x10 -> 0xDEAD77EF.
REQ-034 SHALL cover: lw addr 0x12, sh addr 0x21, lw funct3 011, and lw addr 4*DEPTH_WORDS -> each resp_err = 1, resp_rdata = 0, memory unchanged.
REQ-035 SHALL cover: req_valid held high for 8 requests -> req_ready low in WAIT/RESP, exactly 8 resp_valid pulses spaced 4 cycles apart.
REQ-036 SHALL cover: sw accepted, reset = 0 one cycle later -> no resp_valid, req_ready = 1 after reset, subsequent lw returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated RV32I load/store responder over word-wide byte-lane storage
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode, evaluated against the live request so everything the
    // response needs can be captured on the acceptance edge.
    logic [AW-1:0] acc_idx;
    logic [1:0]    lane;
    logic          size_err;
    logic          f3_err;
    logic          range_err;
    logic          acc_err;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic [31:0]   acc_rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_val;
    logic [31:0]   acc_result;

    // Captured transaction
    logic          err_q;
    logic [31:0]   result_q;
    logic          wr_ok_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] idx_q;

    // Write port selection
    logic          wr_en;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [AW-1:0] wr_idx;

    assign accept = req_valid && (state == IDLE);

    // Legality check, lane decode and load extraction for the presented request
    always_comb begin
        lane      = req_addr[1:0];
        acc_idx   = req_addr[2 +: AW];
        acc_rword = mem[acc_idx];

        size_err = 1'b0;
        case (req_funct3[1:0])
            2'b01:   size_err = req_addr[0];
            2'b10:   size_err = (req_addr[1:0] != 2'b00);
            default: size_err = 1'b0;
        endcase

        if (req_we) begin
            f3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            f3_err = (req_funct3 inside {3'b011, 3'b110, 3'b111});
        end

        range_err = (req_addr[31:2] >= DEPTH_LIM);
        acc_err   = size_err || f3_err || range_err;

        case (req_funct3[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << lane;
                acc_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                acc_be    = lane[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = req_wdata;
            end
        endcase

        rbyte = acc_rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? acc_rword[31:16] : acc_rword[15:0];

        case (req_funct3)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_val = {24'h0, rbyte};
            3'b101:  load_val = {16'h0, rhalf};
            default: load_val = acc_rword;
        endcase

        // Stores and rejected requests always answer with zero data
        acc_result = (req_we || acc_err) ? 32'h0 : load_val;
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Capture the decoded transaction when it is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q    <= 1'b0;
            result_q <= 32'h0;
            wr_ok_q  <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            idx_q    <= '0;
        end else if (accept) begin
            err_q    <= acc_err;
            result_q <= acc_result;
            wr_ok_q  <= req_we && !acc_err;
            be_q     <= acc_be;
            wdata_q  <= acc_wdata;
            idx_q    <= acc_idx;
        end
    end

    // Stores commit on the edge entering RESP; with no wait states that is the
    // acceptance edge itself, so the live decode is used instead of the capture.
    always_comb begin
        wr_en   = 1'b0;
        wr_be   = be_q;
        wr_data = wdata_q;
        wr_idx  = idx_q;
        if ((WAIT_STATES == 0) && (state == IDLE) && accept) begin
            wr_en   = req_we && !acc_err;
            wr_be   = acc_be;
            wr_data = acc_wdata;
            wr_idx  = acc_idx;
        end else if ((state == WAIT) && (cnt == 4'd1)) begin
            wr_en = wr_ok_q;
        end
    end

    // Storage write port; contents survive reset, and a reset edge suppresses the commit
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response outputs are forced to zero outside the RESP cycle
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? result_q : 32'h0;
        resp_err   = resp_valid && err_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks;
    int fails;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_STATES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, return at the negedge of the response cycle
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int  lat;
        bit  acc;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " accepted"}, 32'(acc), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (lat == 1) begin
                chk({tag, " idle outputs"}, {resp_rdata[30:0], resp_err}, 32'h0);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd3);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    endtask

    initial begin
        int acc;
        int pulses;
        int last;
        int gaps_bad;
        int rd_bad;
        int ready_bad;
        int nready;
        int seen;

        checks     = 0;
        fails      = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'd0);

        // Word store then load
        do_req("sw 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Sub-word loads with sign/zero extension
        do_req("lb 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req("lbu 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        do_req("lh 0x10", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

        // Byte store merges into the word
        do_req("sb 0x11", 1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0, 1'b0);
        do_req("lw 0x10 after sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

        // Rejected requests
        do_req("sw 0x20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        do_req("lw 0x12 misaligned", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        do_req("sh 0x21 misaligned", 1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("load f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req("lw out of range", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req("store f3 011", 1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("sw out of range", 1'b1, 3'b010, 32'h410, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("lw 0x20 unchanged", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);
        do_req("lw 0x10 unchanged", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

        // Back-to-back requests with req_valid held high
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        acc = 0; pulses = 0; last = -1; gaps_bad = 0; rd_bad = 0; ready_bad = 0; nready = 0;
        for (int c = 0; c < 60; c++) begin
            if (acc == 8) req_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                if (last >= 0 && (c - last) != 4) gaps_bad++;
                last = c;
                if (resp_rdata !== 32'hDEAD77EF) rd_bad++;
                if (req_ready) ready_bad++;
            end
            if (!req_ready) nready++;
            if (req_valid && req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("burst accepts", 32'(acc), 32'd8);
        chk("burst pulses", 32'(pulses), 32'd8);
        chk("burst spacing errors", 32'(gaps_bad), 32'd0);
        chk("burst rdata errors", 32'(rd_bad), 32'd0);
        chk("burst ready in RESP", 32'(ready_bad), 32'd0);
        chk("burst not-ready cycles", 32'(nready), 32'd24);

        // Reset during WAIT aborts a store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hCAFEF00D;
        chk("abort ready before", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("abort ready after reset", 32'(req_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("abort no response", 32'(seen), 32'd0);
        do_req("lw 0x10 after abort", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
